ram_cleaner: RTL and testbench

- Responder to the decompressor's end-of-job handshake.
- The job controller raises job_decompressed (a level) when all parsers and history RAMs have drained. This block then sweeps every address of the NUM_RAM history RAM banks, writing zeros through a dedicated clean port.
- When the sweep is done it pulses cl_finish, which returns the controller to idle. It then waits for job_decompressed to drop before it can be triggered again.

---
 rtl/ram_cleaner.sv | 139 +++++++++++++
 tb/tb_ram_cleaner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cleaner.sv
// ram_cleaner: zeroes every history RAM bank after a decompression job.
// A rising edge on job_decompressed starts a sweep. The sweep writes each
// address once, in ascending order, through the dedicated clean port of all
// NUM_RAM banks in parallel. It then pulses cl_finish and waits for
// job_decompressed to drop.
// Optional feature: define RAM_CLEAN_HWM_EN to sweep only up to the highest
// address written since the last trigger. A job with no writes skips the sweep.
module ram_cleaner #(
    parameter int NUM_RAM    = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_decompressed,
    input  logic                  clean_stall,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [NUM_RAM-1:0]    clean_wr_en,
    output logic [ADDR_WIDTH-1:0] clean_addr,
    output logic                  cleaning,
    output logic                  cl_finish
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAN    = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t                state;
    logic                  job_d;
    // One bit wider than an address so the compare against the last address
    // happens before any wrap.
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  skip_sweep;
    logic                  trigger;
    logic                  start;

    assign trigger = job_decompressed & ~job_d;
    assign start   = trigger && (state == IDLE);

    // Delayed copy of job_decompressed for rising-edge detection.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch and clk is the only sensitivity.
        if (!rst_n) begin
            job_d <= 1'b0;
        end else begin
            job_d <= job_decompressed;
        end
    end

`ifdef RAM_CLEAN_HWM_EN
    logic                  hwm_valid;
    logic [ADDR_WIDTH-1:0] hwm;
    logic [ADDR_WIDTH-1:0] last_q;

    // Track the highest written address since the last accepted trigger.
    // A write in the trigger cycle counts toward the next job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hwm_valid <= 1'b0;
            hwm       <= '0;
            last_q    <= '0;
        end else if (start) begin
            last_q    <= hwm;
            hwm_valid <= wr_valid;
            hwm       <= wr_valid ? wr_addr : '0;
        end else if (wr_valid && (!hwm_valid || (wr_addr > hwm))) begin
            hwm_valid <= 1'b1;
            hwm       <= wr_addr;
        end
    end

    assign last_addr  = last_q;
    assign skip_sweep = ~hwm_valid;
`else
    // Without the high-water mark, every sweep covers the full bank depth.
    logic unused_hwm_inputs;
    assign unused_hwm_inputs = ^{wr_valid, wr_addr};
    assign last_addr         = '1;
    assign skip_sweep        = 1'b0;
`endif

    // Sweep controller: drives the registered clean port and the handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            clean_wr_en <= '0;
            clean_addr  <= '0;
            cleaning    <= 1'b0;
            cl_finish   <= 1'b0;
        end else begin
            // NOTE: the strobe outputs default low every cycle, so each state only states when they pulse high.
            clean_wr_en <= '0;
            cl_finish   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (skip_sweep) begin
                            state <= DONE;
                        end else begin
                            state    <= CLEAN;
                            cleaning <= 1'b1;
                        end
                    end
                end
                CLEAN: begin
                    // A stalled cycle holds both the address and the counter, so no address is skipped or written twice.
                    if (!clean_stall) begin
                        clean_wr_en <= '1;
                        clean_addr  <= count[ADDR_WIDTH-1:0];
                        count       <= count + 1'b1;
                        if (count == {1'b0, last_addr}) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    cleaning  <= 1'b0;
                    cl_finish <= 1'b1;
                    state     <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!job_decompressed) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cleaner.sv
// Testbench for ram_cleaner, built with ADDR_WIDTH=4 and 16 banks.
// The reference model works at the transaction level. A sweep is expected to
// write addresses 0..last in order, one per unstalled cycle, and to pulse
// cl_finish on the cycle after the last write. The high-water mark, when
// RAM_CLEAN_HWM_EN is defined, is modelled as a plain running maximum.
module tb_ram_cleaner;

    localparam int NUM_RAM    = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic                  clk;
    logic                  rst_n;
    logic                  job_decompressed;
    logic                  clean_stall;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_RAM-1:0]    clean_wr_en;
    logic [ADDR_WIDTH-1:0] clean_addr;
    logic                  cleaning;
    logic                  cl_finish;

    int tests = 0;
    int fails = 0;
    int m_hwm = -1;     // highest written address since last trigger, -1 = none
    bit wr_rand = 1'b0; // randomize history writes every cycle

    ram_cleaner #(
        .NUM_RAM   (NUM_RAM),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_decompressed(job_decompressed),
        .clean_stall     (clean_stall),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .clean_wr_en     (clean_wr_en),
        .clean_addr      (clean_addr),
        .cleaning        (cleaning),
        .cl_finish       (cl_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, update the write model, settle.
    task automatic drive(input logic j, input logic s);
        job_decompressed = j;
        clean_stall      = s;
        if (wr_rand) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
        end
        @(posedge clk);
        if (!rst_n) m_hwm = -1;
        else if (wr_valid && int'(wr_addr) > m_hwm) m_hwm = int'(wr_addr);
        #1;
    endtask

    // Expect the block to be quiet: no writes, not cleaning, no finish pulse.
    task automatic expect_quiet(input string name);
        tests++;
        if (clean_wr_en !== '0 || cleaning !== 1'b0 || cl_finish !== 1'b0) begin
            fails++;
            $display("FAIL %s: wr_en=%h cleaning=%b cl_finish=%b, required 0/0/0",
                     name, clean_wr_en, cleaning, cl_finish);
        end
    endtask

    // Trigger a job and follow it cycle by cycle against the transaction model.
    // stall_at/stall_len: forced stall when about to write that address.
    // rnd: extra random stalls. drop_at: job falls once that many writes are done.
    // abort_after: return as soon as that many writes have been observed.
    task automatic do_sweep(input string name, input int stall_at, input int stall_len,
                            input bit rnd, input int drop_at, input int abort_after);
        int last;
        int writes = 0;
        int stalled = 0;
        int n = 0;
        int exp_addr;
        logic s;
        logic [NUM_RAM-1:0] exp_en;
`ifdef RAM_CLEAN_HWM_EN
        last = m_hwm;
`else
        last = DEPTH - 1;
`endif
        m_hwm = -1;
        drive(1'b1, 1'b0);
        tests++;
        if (clean_wr_en !== '0 || cleaning !== (last >= 0) || cl_finish !== 1'b0) begin
            fails++;
            $display("FAIL %s trigger: wr_en=%h cleaning=%b cl_finish=%b, required 0/%0b/0",
                     name, clean_wr_en, cleaning, cl_finish, last >= 0);
        end
        while (writes <= last) begin
            if (writes == stall_at && stalled < stall_len) begin
                s = 1'b1;
                stalled++;
            end else begin
                s = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            drive(writes < drop_at, s);
            n++;
            exp_en   = s ? '0 : '1;
            exp_addr = s ? writes - 1 : writes;
            tests++;
            if (clean_wr_en !== exp_en || cleaning !== 1'b1 || cl_finish !== 1'b0 ||
                (exp_addr >= 0 && clean_addr !== exp_addr[ADDR_WIDTH-1:0])) begin
                fails++;
                $display("FAIL %s T+%0d: wr_en=%h addr=%0d cleaning=%b cl_finish=%b, required %h/%0d/1/0",
                         name, n, clean_wr_en, clean_addr, cleaning, cl_finish, exp_en, exp_addr);
            end
            if (!s) writes++;
            if (writes == abort_after) return;
        end
        drive(writes < drop_at, 1'($urandom_range(0, 1)));
        n++;
        tests++;
        if (cl_finish !== 1'b1 || clean_wr_en !== '0 || cleaning !== 1'b0) begin
            fails++;
            $display("FAIL %s finish T+%0d: cl_finish=%b wr_en=%h cleaning=%b, required 1/0/0",
                     name, n, cl_finish, clean_wr_en, cleaning);
        end
    endtask

    // Hold job high for hold cycles (must not retrigger), then drop it.
    task automatic release_job(input string name, input int hold);
        for (int i = 0; i < hold; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)));
            expect_quiet({name, " hold"});
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
            expect_quiet({name, " low"});
        end
    endtask

    // One idle cycle that writes the top address, so a HWM build sweeps fully.
    task automatic prime();
        wr_valid = 1'b1;
        wr_addr  = ADDR_WIDTH'(DEPTH - 1);
        drive(1'b0, 1'b0);
        wr_valid = 1'b0;
        expect_quiet("prime");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tests++;
            if (clean_wr_en !== '0 || clean_addr !== '0 || cleaning !== 1'b0 || cl_finish !== 1'b0) begin
                fails++;
                $display("FAIL reset: wr_en=%h addr=%0d cleaning=%b cl_finish=%b, required all 0",
                         clean_wr_en, clean_addr, cleaning, cl_finish);
            end
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
        expect_quiet("post_reset");
    endtask

    task automatic test_full_sweep();
        prime();
        do_sweep("full", -1, 0, 1'b0, 99, -1);
        release_job("full", 1);
    endtask

    task automatic test_stall();
        prime();
        do_sweep("stall5", 5, 3, 1'b0, 99, -1);
        release_job("stall5", 1);
    endtask

    task automatic test_last_stall();
        prime();
        do_sweep("stall_last", DEPTH - 1, 2, 1'b0, 99, -1);
        release_job("stall_last", 1);
    endtask

    task automatic test_handshake();
        prime();
        do_sweep("hs_first", -1, 0, 1'b0, 99, -1);
        release_job("hs", 10);
        prime();
        do_sweep("hs_second", -1, 0, 1'b0, 99, -1);
        release_job("hs2", 1);
    endtask

    task automatic test_job_drop();
        prime();
        do_sweep("job_drop", -1, 0, 1'b0, 4, -1);
        release_job("job_drop", 0);
    endtask

    task automatic test_reset_mid();
        prime();
        do_sweep("pre_reset", -1, 0, 1'b0, 99, 8);
        rst_n = 1'b0;
        drive(1'b1, 1'b0);
        tests++;
        if (clean_wr_en !== '0 || clean_addr !== '0 || cleaning !== 1'b0 || cl_finish !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: wr_en=%h addr=%0d cleaning=%b cl_finish=%b, required all 0",
                     clean_wr_en, clean_addr, cleaning, cl_finish);
        end
        rst_n = 1'b1;
        do_sweep("after_reset", -1, 0, 1'b0, 99, -1);
        release_job("after_reset", 1);
    endtask

`ifdef RAM_CLEAN_HWM_EN
    task automatic test_hwm();
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        drive(1'b0, 1'b0);
        wr_addr  = 4'd9;
        drive(1'b0, 1'b0);
        wr_valid = 1'b0;
        do_sweep("hwm_9", -1, 0, 1'b0, 99, -1);
        release_job("hwm_9", 1);
        do_sweep("hwm_empty", -1, 0, 1'b0, 99, -1);
        release_job("hwm_empty", 2);
    endtask
`endif

    task automatic test_random();
        wr_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            do_sweep("random", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
                     1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH)) : 99, -1);
            release_job("random", int'($urandom_range(0, 4)));
        end
        wr_rand  = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        job_decompressed = 1'b0;
        clean_stall      = 1'b0;
        test_reset();
        test_full_sweep();
        test_stall();
        test_last_stall();
        test_handshake();
        test_job_drop();
        test_reset_mid();
`ifdef RAM_CLEAN_HWM_EN
        test_hwm();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
